// File: rtl/mem_responder_pkg.sv
// Shared definitions for mem_responder: FSM state encodings and default widths
// matching the multicycle processor's data path.
package mem_responder_pkg;
  localparam int DEF_ADDR_WIDTH = 26;
  localparam int DEF_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    RSP_IDLE   = 2'd0,
    RSP_ACCESS = 2'd1,
    RSP_DONE   = 2'd2
  } rsp_state_t;
endpackage

// File: rtl/mem_word_array.sv
// DEPTH x DATA_WIDTH word storage: synchronous write, combinational read.
// Contents are deliberately not reset.
module mem_word_array #(
  parameter int DEPTH      = 1024,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_W-1:0]      idx,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[idx] <= wdata;

  assign rdata = mem[idx];
endmodule

// File: rtl/mem_responder.sv
// Memory-side responder with programmable latency and READY handshake.
// Optional completed-access counters under MEM_RESPONDER_STATS_EN.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = 1024,
  parameter int LATENCY    = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  READ,
  input  logic                  WRITE,
  input  logic [ADDR_WIDTH-1:0] ADDR,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic                  READY,
  output logic                  BUSY,
  output logic                  ERR,
  output logic [15:0]           RD_COUNT,
  output logic [15:0]           WR_COUNT
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

  rsp_state_t            state;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_data;
  logic                  lat_wr;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  in_range, fire, we;

  // Full-width compare so aliased high addresses are rejected, not wrapped.
  assign in_range = {1'b0, lat_addr} < DEPTH_W;
  assign fire     = (state == RSP_ACCESS) && (cnt == 4'd0);
  assign we       = fire && lat_wr && in_range;

  mem_word_array #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH), .IDX_W(IDX_W)) u_array (
    .clk  (CLK),
    .we   (we),
    .idx  (lat_addr[IDX_W-1:0]),
    .wdata(lat_data),
    .rdata(rdata)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= RSP_IDLE;
      cnt      <= '0;
      lat_addr <= '0;
      lat_data <= '0;
      lat_wr   <= 1'b0;
      DATA_OUT <= '0;
      READY    <= 1'b0;
      BUSY     <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      ERR <= 1'b0;
      case (state)
        RSP_IDLE: begin
          if (READ ^ WRITE) begin
            lat_addr <= ADDR;
            lat_data <= DATA_IN;
            lat_wr   <= WRITE;
            cnt      <= LAT_M1;
            BUSY     <= 1'b1;
            state    <= RSP_ACCESS;
          end else if (READ && WRITE) begin
            ERR <= 1'b1;
          end
        end
        RSP_ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (!lat_wr) DATA_OUT <= in_range ? rdata : '0;
            ERR   <= !in_range;
            READY <= 1'b1;
            BUSY  <= 1'b0;
            state <= RSP_DONE;
          end
        end
        RSP_DONE: begin
          if (!READ && !WRITE) begin
            READY <= 1'b0;
            state <= RSP_IDLE;
          end
        end
        default: state <= RSP_IDLE;
      endcase
    end
  end

`ifdef MEM_RESPONDER_STATS_EN
  logic [15:0] rd_q, wr_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_q <= '0;
      wr_q <= '0;
    end else if (fire && in_range) begin
      if (lat_wr) wr_q <= wr_q + 16'd1;
      else        rd_q <= rd_q + 16'd1;
    end
  end

  assign RD_COUNT = rd_q;
  assign WR_COUNT = wr_q;
`else
  assign RD_COUNT = '0;
  assign WR_COUNT = '0;
`endif
endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: four instances with LATENCY 1..4,
// each checked against a per-instance word-array/counter reference model.
module tb_mem_responder;
  localparam int N  = 4;
  localparam int AW = 26;
  localparam int DW = 32;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [N-1:0]         rd, wr, ready, busy, err;
  logic [N-1:0][AW-1:0] addr;
  logic [N-1:0][DW-1:0] din, dout;
  logic [N-1:0][15:0]   rdc, wrc;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mm [N][1024];
  logic [DW-1:0] exp_dout [N];
  int            exp_rd [N];
  int            exp_wr [N];

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_responder #(.LATENCY(g + 1)) u_dut (
      .CLK(CLK), .RST(RST), .READ(rd[g]), .WRITE(wr[g]), .ADDR(addr[g]),
      .DATA_IN(din[g]), .DATA_OUT(dout[g]), .READY(ready[g]), .BUSY(busy[g]),
      .ERR(err[g]), .RD_COUNT(rdc[g]), .WR_COUNT(wrc[g])
    );
  end

  function automatic int cnt_exp(int v);
`ifdef MEM_RESPONDER_STATS_EN
    return v & 16'hFFFF;
`else
    return 0;
`endif
  endfunction

  // Pulse reset; outputs must clear while RST is still low.
  task automatic do_reset();
    RST = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      total++;
      if ({dout[i], ready[i], busy[i], err[i], rdc[i], wrc[i]} !== '0)
        $display("FAIL reset[%0d]: dout=%h rdy=%b busy=%b err=%b rdc=%0d wrc=%0d, required all 0",
                 i, dout[i], ready[i], busy[i], err[i], rdc[i], wrc[i]);
      if ({dout[i], ready[i], busy[i], err[i], rdc[i], wrc[i]} !== '0) bad++;
      exp_dout[i] = '0; exp_rd[i] = 0; exp_wr[i] = 0;
    end
    @(posedge CLK); #1;
    RST = 1'b1;
  endtask

  // One full handshake on instance i; latency expected is i+1 edges.
  task automatic do_access(input int i, input bit w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input int hold, input bit drop);
    int lat = i + 1;
    bit oor = (a >= 26'd1024);
    int k, busy_n;
    bit got = 0;
    @(posedge CLK); #1;
    rd[i] = !w; wr[i] = w; addr[i] = a; din[i] = d;
    @(posedge CLK); #1;
    busy_n = (busy[i] === 1'b1) ? 1 : 0;
    addr[i] = AW'($urandom); din[i] = $urandom;
    if (drop) begin rd[i] = 0; wr[i] = 0; end
    for (k = 1; k <= 40; k++) begin
      @(posedge CLK); #1;
      if (ready[i] === 1'b1) begin got = 1; break; end
      if (busy[i] === 1'b1) busy_n++;
    end
    total++;
    if (!got || k != lat) begin
      bad++;
      $display("FAIL latency[%0d]: got=%0b edges=%0d, required %0d", i, got, k, lat);
    end
    if (!got) begin rd[i] = 0; wr[i] = 0; return; end
    total++;
    if (busy_n != lat || busy[i] !== 1'b0) begin
      bad++;
      $display("FAIL busy[%0d]: high %0d cycles, at ready=%b, required %0d and 0", i, busy_n, busy[i], lat);
    end
    if (!oor) begin
      if (w) begin mm[i][a[9:0]] = d; exp_wr[i]++; end
      else exp_rd[i]++;
    end
    if (!w) exp_dout[i] = oor ? '0 : mm[i][a[9:0]];
    total++;
    if (err[i] !== oor) begin
      bad++;
      $display("FAIL err[%0d]: %b, required %b (addr %0d)", i, err[i], oor, a);
    end
    total++;
    if (dout[i] !== exp_dout[i]) begin
      bad++;
      $display("FAIL dout[%0d]: %h, required %h (addr %0d)", i, dout[i], exp_dout[i], a);
    end
    total++;
    if (int'(rdc[i]) != cnt_exp(exp_rd[i]) || int'(wrc[i]) != cnt_exp(exp_wr[i])) begin
      bad++;
      $display("FAIL counts[%0d]: rd=%0d wr=%0d, required rd=%0d wr=%0d", i, rdc[i], wrc[i],
               cnt_exp(exp_rd[i]), cnt_exp(exp_wr[i]));
    end
    if (!drop) begin
      for (int h = 0; h < hold; h++) begin
        @(posedge CLK); #1;
        total++;
        if ({ready[i], busy[i], err[i]} !== 3'b100 || dout[i] !== exp_dout[i]) begin
          bad++;
          $display("FAIL hold[%0d]: rdy/busy/err=%b dout=%h, required 100 %h", i,
                   {ready[i], busy[i], err[i]}, dout[i], exp_dout[i]);
        end
      end
      rd[i] = 0; wr[i] = 0;
    end
    @(posedge CLK); #1;
    total++;
    if ({ready[i], busy[i], err[i]} !== 3'b000 || dout[i] !== exp_dout[i]) begin
      bad++;
      $display("FAIL release[%0d]: rdy/busy/err=%b dout=%h, required 000 %h", i,
               {ready[i], busy[i], err[i]}, dout[i], exp_dout[i]);
    end
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_write_read();
    do_access(1, 1, 26'd5, 32'hDEADBEEF, 0, 0);
    do_access(1, 0, 26'd5, 32'h0, 0, 0);
  endtask

  task automatic test_latency_sweep();
    do_access(0, 1, 26'd0, 32'h12345678, 0, 0);
    do_access(0, 0, 26'd0, 32'h0, 0, 0);
    do_access(3, 1, 26'd0, 32'h12345678, 0, 0);
    do_access(3, 0, 26'd0, 32'h0, 0, 0);
  endtask

  task automatic test_conflict_range();
    @(posedge CLK); #1;
    rd[1] = 1; wr[1] = 1; addr[1] = 26'd5; din[1] = 32'h0BAD0BAD;
    @(posedge CLK); #1;
    total++;
    if ({err[1], busy[1], ready[1]} !== 3'b100) begin
      bad++;
      $display("FAIL conflict: err/busy/rdy=%b, required 100", {err[1], busy[1], ready[1]});
    end
    rd[1] = 0; wr[1] = 0;
    @(posedge CLK); #1;
    total++;
    if ({err[1], busy[1], ready[1]} !== 3'b000) begin
      bad++;
      $display("FAIL conflict_clear: err/busy/rdy=%b, required 000", {err[1], busy[1], ready[1]});
    end
    do_access(1, 0, 26'd5, 32'h0, 0, 0);
    do_access(1, 0, 26'd1024, 32'h0, 0, 0);
    do_access(1, 1, 26'd1029, 32'hFFFF0000, 0, 0);
    do_access(1, 0, 26'd5, 32'h0, 0, 0);
  endtask

  task automatic test_hold_drop();
    do_access(1, 0, 26'd5, 32'h0, 5, 0);
    do_access(3, 0, 26'd0, 32'h0, 0, 1);
    do_access(1, 1, 26'd9, 32'h0F0F1234, 0, 1);
    do_access(1, 0, 26'd9, 32'h0, 0, 0);
  endtask

  task automatic test_reset_mid_write();
    do_access(2, 1, 26'd7, 32'h11112222, 0, 0);
    @(posedge CLK); #1;
    wr[2] = 1; addr[2] = 26'd7; din[2] = 32'hA5A5A5A5;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    wr[2] = 0;
    do_reset();
    do_access(2, 0, 26'd7, 32'h0, 0, 0);
  endtask

  task automatic test_stats();
    do_reset();
    do_access(0, 1, 26'd3, 32'h33333333, 0, 0);
    do_access(0, 1, 26'd4, 32'h44444444, 0, 0);
    do_access(0, 0, 26'd3, 32'h0, 0, 0);
    do_access(0, 0, 26'd4, 32'h0, 1, 0);
    do_access(0, 0, 26'd3, 32'h0, 0, 0);
    do_access(0, 0, 26'd2000, 32'h0, 0, 0);
    total++;
`ifdef MEM_RESPONDER_STATS_EN
    if (rdc[0] !== 16'd3 || wrc[0] !== 16'd2) begin
      bad++;
      $display("FAIL stats: rd=%0d wr=%0d, required rd=3 wr=2", rdc[0], wrc[0]);
    end
`else
    if (rdc[0] !== 16'd0 || wrc[0] !== 16'd0) begin
      bad++;
      $display("FAIL stats: rd=%0d wr=%0d, required rd=0 wr=0", rdc[0], wrc[0]);
    end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < N; i++)
      for (int a = 0; a < 16; a++)
        do_access(i, 1, AW'(a), $urandom, 0, 0);
    for (int n = 0; n < 40; n++) begin
      int i = $urandom_range(0, N - 1);
      bit w = $urandom_range(0, 1) == 1;
      logic [AW-1:0] a = ($urandom_range(0, 7) == 0) ? AW'(1024 + $urandom_range(0, 100000))
                                                      : AW'($urandom_range(0, 15));
      bit drop = (i > 0) && ($urandom_range(0, 3) == 0);
      do_access(i, w, a, $urandom, $urandom_range(0, 3), drop);
    end
  endtask

  initial begin
    rd = '0; wr = '0; addr = '0; din = '0;
    #2;
    test_reset();
    test_write_read();
    test_latency_sweep();
    test_conflict_range();
    test_hold_drop();
    test_reset_mid_write();
    test_stats();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
